// File: rtl/nbits_pkg.sv
// nbits_pkg: shared state encoding and default width for the N-bit datapath blocks
package nbits_pkg;
  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;
  localparam int NBITS_DEFAULT = 4;
endpackage

// File: rtl/mod_n_counter.sv
// mod_n_counter: bit counter with clear, increment and terminal (count == N-1) flag
module mod_n_counter #(
  parameter int N  = 4,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          term
);
  logic [CW-1:0] count_q, count_d;
  // Reset and clear dominate increment
  always_comb count_d = clr ? '0 : inc ? count_q + CW'(1) : count_q;
  // Count register
  always_ff @(posedge clk) count_q <= rst ? '0 : count_d;
  assign count = count_q;
  assign term  = count_q == CW'(N - 1);
endmodule

// File: rtl/serial_to_parallel_nbits.sv
// serial_to_parallel_nbits: collects N serial bits MSB-first and hands the word off via valid/ready
module serial_to_parallel_nbits
  import nbits_pkg::*;
#(
  parameter int N  = NBITS_DEFAULT,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          in_valid,
  input  logic          in_bit,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_word,
  output logic [CW-1:0] bit_count
);
  state_t       state_q, state_d;
  logic [N-1:0] word_q, word_d;
  logic         accept, hs, term;
  assign accept = in_valid && state_q == FILL;
  assign hs     = out_ready && state_q == HOLD;
  mod_n_counter #(.N(N), .CW(CW)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (accept),
    .clr  (clear || hs),
    .count(bit_count),
    .term (term)
  );
  // Next state and shifted word; clear or handshake zero the word so FILL shows a zero-padded partial
  always_comb begin
    state_d = (clear || hs) ? FILL : (accept && term) ? HOLD : state_q;
    word_d  = (clear || hs) ? '0 : accept ? {word_q[N-2:0], in_bit} : word_q;
  end
  // State and shift registers
  always_ff @(posedge clk) begin
    state_q <= rst ? FILL : state_d;
    word_q  <= rst ? '0 : word_d;
  end
  assign in_ready  = state_q == FILL;
  assign out_valid = state_q == HOLD;
  assign out_word  = word_q;
endmodule

// File: tb/tb_serial_to_parallel_nbits.sv
// tb_serial_to_parallel_nbits: directed checks of fill, hold, handshake, clear and reset behaviour
module tb_serial_to_parallel_nbits;
  localparam int N = 4;
  localparam int CW = $clog2(N + 1);
  logic clk = 0, rst = 1, clear = 0, in_valid = 0, in_bit = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [N-1:0] out_word;
  logic [CW-1:0] bit_count;
  int n_cmp = 0, n_err = 0;

  serial_to_parallel_nbits #(.N(N)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic b);
    in_valid = 1;
    in_bit = b;
    tick();
    in_valid = 0;
  endtask

  task automatic chk_all(input string tag, input logic [N-1:0] w, input int c,
                         input logic v, input logic r);
    chk({tag, ".word"}, 32'(out_word), 32'(w));
    chk({tag, ".cnt"}, 32'(bit_count), 32'(c));
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".ready"}, 32'(in_ready), 32'(r));
  endtask

  initial begin
    in_valid = 1;
    in_bit = 1;
    tick();
    chk_all("rst1", 4'b0000, 0, 0, 1);
    tick();
    chk_all("rst2", 4'b0000, 0, 0, 1);
    rst = 0;
    in_valid = 0;
    in_bit = 0;

    out_ready = 1;
    send(1); send(0); send(1);
    chk_all("s1010_3", 4'b0101, 3, 0, 1);
    send(0);
    chk_all("s1010_4", 4'b1010, 4, 1, 0);
    chk("s1010_and", 32'(&out_word), 32'(0));
    tick();
    chk_all("s1010_hs", 4'b0000, 0, 0, 1);

    out_ready = 0;
    send(1); send(1); send(1); send(1);
    chk_all("s1111", 4'b1111, 4, 1, 0);
    chk("s1111_and", 32'(&out_word), 32'(1));
    in_valid = 1;
    in_bit = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all("hold", 4'b1111, 4, 1, 0);
    end
    in_valid = 0;
    out_ready = 1;
    tick();
    chk_all("hold_hs", 4'b0000, 0, 0, 1);
    out_ready = 0;

    send(0);
    chk("gap_c1", 32'(bit_count), 32'(1));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gap_idle3", 32'(bit_count), 32'(1));
    end
    send(0);
    chk("gap_c2", 32'(bit_count), 32'(2));
    tick();
    chk("gap_idle1", 32'(bit_count), 32'(2));
    send(0);
    chk("gap_c3", 32'(bit_count), 32'(3));
    send(0);
    chk_all("gap_done", 4'b0000, 4, 1, 0);
    chk("gap_and", 32'(&out_word), 32'(0));
    out_ready = 1;
    tick();
    out_ready = 0;
    chk_all("gap_hs", 4'b0000, 0, 0, 1);

    send(1); send(1);
    chk_all("clr_pre", 4'b0011, 2, 0, 1);
    clear = 1;
    in_valid = 1;
    in_bit = 1;
    tick();
    clear = 0;
    in_valid = 0;
    chk_all("clr_post", 4'b0000, 0, 0, 1);
    send(0); send(1); send(0); send(1);
    chk_all("clr_0101", 4'b0101, 4, 1, 0);

    clear = 1;
    out_ready = 1;
    tick();
    clear = 0;
    out_ready = 0;
    chk_all("clr_hs", 4'b0000, 0, 0, 1);
    tick();
    chk_all("clr_hs_idle", 4'b0000, 0, 0, 1);

    send(1); send(1); send(1);
    chk_all("rst_pre", 4'b0111, 3, 0, 1);
    rst = 1;
    in_valid = 1;
    in_bit = 1;
    tick();
    rst = 0;
    in_valid = 0;
    chk_all("rst_mid", 4'b0000, 0, 0, 1);
    tick();
    chk_all("rst_mid_idle", 4'b0000, 0, 0, 1);
    send(1);
    chk_all("rst_msb", 4'b0001, 1, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/serial_to_parallel_nbits.md
# serial_to_parallel_nbits

Serial-to-parallel collector that assembles `N` serially received bits into an `N`-bit word and presents it, with a valid/ready handshake, to the downstream `andNbits` reduction stage. It is the stage directly upstream of the N-bit AND reducer: its `out_word` drives the reducer's `X` input. The first bit received lands in the MSB, so the serial stream 1,0,1,0 yields word `1010`.

## Interface
- `N`, default 4: word width; legal range N ≥ 2.
- `CW`, default $clog2(N+1): width of `bit_count`.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `clear`  in  1: synchronous discard of the partial or held word.
- `in_valid`  in  1: `in_bit` is valid this cycle.
- `in_bit`  in  1: serial data bit.
- `in_ready`  out  1: block accepts a bit this cycle.
- `out_valid`  out  1: `out_word` holds a complete word.
- `out_ready`  in  1: downstream consumes the word this cycle.
- `out_word`  out  N: assembled word, MSB = first bit received.
- `bit_count`  out  CW: bits accepted into the current word, 0..N.

## Operation
- Two states: FILL and HOLD. Reset state is FILL.
- Reset values: `out_valid`=0, `out_word`=0, `bit_count`=0, state FILL, `in_ready`=1 from the first cycle after the reset edge.
- `in_ready` = (state == FILL). `out_valid` = (state == HOLD). Both are decoded from the registered state, not from inputs.
- FILL, accept (`in_valid && in_ready`):
  - `out_word` <= {out_word[N-2:0], in_bit}.
  - `bit_count` <= bit_count+1.
  - If `bit_count` == N-1 before the edge, the next state is HOLD and `bit_count` becomes N.
- FILL with `in_valid`=0: no change.
- HOLD: `out_word` and `bit_count` are frozen. `in_bit`/`in_valid` are ignored.
- HOLD with `out_ready`=1: this is the handshake. Next state is FILL, `bit_count` <= 0, `out_word` <= 0.
- HOLD with `out_ready`=0: the block stays in HOLD indefinitely.
- `clear`=1, any state: next state FILL, `bit_count` <= 0, `out_word` <= 0. Any accept or handshake in that cycle is discarded.
- Priority: `rst` > `clear` > handshake/accept.
- `out_ready` is ignored in FILL. `clear` and `out_ready` are never required to be mutually exclusive.

## Timing
- Accepting the Nth bit at edge k makes `out_valid`=1 after edge k. Latency from last bit to valid is 1 cycle.
- Minimum word period is N+1 cycles: N accept cycles plus 1 HOLD cycle with `out_ready`=1.
- No bit is accepted in the cycle the word is consumed. `in_ready` returns to 1 after the handshake edge.
- `rst` or `clear` asserted mid-word discards the partial word in one edge. The next accepted bit is bit 0 (MSB).
- While `rst` is high, every input is ignored. Outputs show reset values after the first reset edge.
- The downstream reducer output is meaningful only while `out_valid`=1. In FILL, `out_word` shows the partial word, zero-padded from the left, which guarantees the reducer reads 0.

## Structure
- Shared package `nbits_pkg`:
  - State typedef: FILL=1'b0, HOLD=1'b1.
  - Default width constant `NBITS_DEFAULT`=4, shared with `andNbits` instances.
- One natural sub-module: `mod_n_counter`.
  - Parameterised CW-bit counter with `inc`, `clr` and terminal flag (`count == N-1`).
  - It drives `bit_count` and the FILL→HOLD decision.
- The shift register and state register stay in the top module.
- The `andNbits` instance lives in the parent, not inside this block.

## Test plan
- Reset: hold `rst` 2 cycles with `in_valid`=1, `in_bit`=1 → `out_word`=0000, `bit_count`=0, `out_valid`=0; `in_ready`=1 after the reset edge.
- Stream 1,0,1,0 (N=4), with `out_ready`=1 → `out_valid`=1 exactly one cycle after the 4th accept, `out_word`=1010, downstream AND=0. The next cycle gives `out_valid`=0, `out_word`=0000, `bit_count`=0.
- Stream 1,1,1,1 with `out_ready`=0 for 5 cycles → `out_word` holds 1111, AND=1, `in_ready`=0. Bits driven during HOLD are not absorbed. Raising `out_ready` completes the handshake in 1 cycle.
- Gaps: stream 0,(idle 3),0,(idle 1),0,0 → `bit_count` steps 1,1,1,1,2,2,3,4; word 0000, AND=0.
- `clear` after 2 bits (1,1), then stream 0,1,0,1 → `out_word`=0101. The cleared bits do not appear.
- `clear` and `out_ready` high together in HOLD; `rst` pulsed at `bit_count`=3 → both return to FILL with `bit_count`=0. No extra word is emitted.
